// File: rtl/dmem_ctrl.sv
// Data-memory stage: owns the data RAM and services byte/half/word loads and stores.
// Sub-word stores are read-modify-write over the synchronous-read array.
module dmem_ctrl #(
   parameter int          ADDR_W    = 11,
   parameter logic [31:0] BASE_ADDR = 32'h10010000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        addr_err
);

   localparam logic [1:0]  IDLE  = 2'd0;
   localparam logic [1:0]  RD    = 2'd1;
   localparam logic [1:0]  RMW   = 2'd2;
   localparam int          DEPTH = 1 << ADDR_W;
   localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'd1 << (ADDR_W + 2));

   logic [31:0]       r_mem [DEPTH];
   logic [31:0]       r_rd_word;
   logic [31:0]       r_rdata;
   logic [1:0]        r_state;
   logic [1:0]        w_state_next;

   logic [31:0]       w_off;
   logic [ADDR_W-1:0] w_idx;
   logic              w_fmt_err;
   logic              w_range_err;
   logic              w_err;
   logic              w_idle;
   logic              w_word_st;
   logic              w_mem_we;
   logic [31:0]       w_mem_wdata;
   logic [31:0]       w_merged;
   logic [3:0]        w_lane_sel;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_ext;

   assign w_off       = addr - BASE_ADDR;
   assign w_idx       = w_off[ADDR_W+1:2];
   assign w_fmt_err   = (size == 2'b11) | ((size == 2'b01) & addr[0]) |
                        ((size == 2'b10) & (addr[1:0] != 2'b00));
   assign w_range_err = (addr < BASE_ADDR) | ({1'b0, addr} >= LIMIT);
   assign w_err       = req & (w_fmt_err | w_range_err);
   assign w_idle      = (r_state == IDLE);
   assign w_word_st   = we & (size == 2'b10);

   // Request fields are held stable through RD/RMW, so the IDLE-time checks still apply there.
   assign addr_err = ~rst & w_idle & w_err;
   assign busy     = ~rst & w_idle & req & ~w_err & ~w_word_st;
   assign done     = ~rst & req & (w_idle ? (w_err | w_word_st)
                                          : ((r_state == RD) | (r_state == RMW)));

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign w_lane_sel[gi] = ((size == 2'b00) & (addr[1:0] == 2'(gi))) |
                                 ((size == 2'b01) & (addr[1] == 1'(gi / 2)));
         if (gi % 2 == 1) begin : g_odd
            // Odd lanes take the high byte of wdata when part of a halfword store.
            assign w_merged[8*gi +: 8] = ~w_lane_sel[gi] ? r_rd_word[8*gi +: 8] :
                                         (size == 2'b01) ? wdata[15:8] : wdata[7:0];
         end else begin : g_even
            assign w_merged[8*gi +: 8] = w_lane_sel[gi] ? wdata[7:0] : r_rd_word[8*gi +: 8];
         end
      end
   endgenerate

   assign w_byte = r_rd_word[{addr[1:0], 3'b000} +: 8];
   assign w_half = r_rd_word[{addr[1], 4'b0000} +: 16];

   always_comb begin
      w_load_ext = r_rd_word;
      case (size)
         2'b00:   w_load_ext = {{24{sign_ext & w_byte[7]}}, w_byte};
         2'b01:   w_load_ext = {{16{sign_ext & w_half[15]}}, w_half};
         default: w_load_ext = r_rd_word;
      endcase
   end

   assign w_mem_we    = ~rst & req & ((w_idle & ~w_err & w_word_st) | (r_state == RMW));
   assign w_mem_wdata = w_idle ? wdata : w_merged;

   always_ff @(posedge clk) begin
      if (w_mem_we)
         r_mem[w_idx] <= w_mem_wdata;
      r_rd_word <= r_mem[w_idx];
   end

   always_comb begin
      w_state_next = IDLE;
      if (w_idle && req && !w_err && !w_word_st)
         w_state_next = we ? RMW : RD;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if (r_state == RD && req)
            r_rdata <= w_load_ext;
      end
   end

   assign rdata = r_rdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: expected completions are queued at issue and
// checked when done fires; rdata is checked on the following cycle.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign_ext = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        addr_err;

   typedef struct {
      string       tag;
      logic        err;
      int          lat;
      logic [31:0] rd;
   } item_t;

   item_t       q[$];
   int          n_tests = 0;
   int          n_fail = 0;
   int          busy_cnt = 0;
   bit          pend = 1'b0;
   logic [31:0] pend_rd;
   string       pend_tag;
   logic [31:0] last_load = 32'd0;

   dmem_ctrl #(.ADDR_W(11), .BASE_ADDR(32'h10010000)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .we       (we),
      .size     (size),
      .sign_ext (sign_ext),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .addr_err (addr_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every completion.
   always @(negedge clk) begin
      if (pend) begin
         check({pend_tag, "_rdata"}, rdata, pend_rd);
         pend = 1'b0;
      end
      if (rst) begin
         busy_cnt = 0;
      end else if (done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            item_t it;
            it = q.pop_front();
            check({it.tag, "_err"}, {31'd0, addr_err}, {31'd0, it.err});
            check({it.tag, "_busy_cycles"}, busy_cnt, it.lat);
            $display("[TB] %s done err=%0b busy_cycles=%0d", it.tag, addr_err, busy_cnt);
            pend     = 1'b1;
            pend_rd  = it.rd;
            pend_tag = it.tag;
         end
         busy_cnt = 0;
      end else if (busy) begin
         busy_cnt++;
      end
   end

   task automatic access(input string tag, input logic w, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] d,
                         input logic exp_err, input int exp_lat, input logic [31:0] exp_rd);
      item_t it;
      bit    got;
      it.tag = tag; it.err = exp_err; it.lat = exp_lat; it.rd = exp_rd;
      q.push_back(it);
      req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
      got = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         void'(q.pop_back());
      end
      @(posedge clk); #1;
   endtask

   task automatic load(input string tag, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] exp);
      access(tag, 1'b0, sz, sx, a, 32'd0, 1'b0, 1, exp);
      last_load = exp;
   endtask

   task automatic store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d);
      access(tag, 1'b1, sz, 1'b0, a, d, 1'b0, (sz == 2'b10) ? 0 : 1, last_load);
   endtask

   task automatic bad(input string tag, input logic w, input logic [1:0] sz,
                      input logic [31:0] a);
      access(tag, w, sz, 1'b0, a, 32'hFFFFFFFF, 1'b1, 0, last_load);
   endtask

   task automatic idle();
      req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, addr_err}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      idle();
      @(negedge clk);
      check("idle_done", {31'd0, done}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;

      store("sw_4",   2'b10, 32'h10010004, 32'hDEADBEEF);
      load ("lw_4",   2'b10, 1'b0, 32'h10010004, 32'hDEADBEEF);
      store("sb_6",   2'b00, 32'h10010006, 32'h00000080);
      load ("lw_4b",  2'b10, 1'b0, 32'h10010004, 32'hDE80BEEF);
      load ("lb_6",   2'b00, 1'b1, 32'h10010006, 32'hFFFFFF80);
      load ("lbu_6",  2'b00, 1'b0, 32'h10010006, 32'h00000080);
      store("sw_0",   2'b10, 32'h10010000, 32'hAAAA5555);
      store("sh_2",   2'b01, 32'h10010002, 32'h00001234);
      load ("lh_2",   2'b01, 1'b1, 32'h10010002, 32'h00001234);
      load ("lhu_2",  2'b01, 1'b0, 32'h10010002, 32'h00001234);
      load ("lw_0",   2'b10, 1'b0, 32'h10010000, 32'h12345555);
      store("sb_3",   2'b00, 32'h10010003, 32'h000000C1);
      load ("lb_3",   2'b00, 1'b1, 32'h10010003, 32'hFFFFFFC1);
      idle();

      bad("lw_mis",   1'b0, 2'b10, 32'h10010001);
      bad("lh_mis",   1'b0, 2'b01, 32'h10010003);
      bad("sw_low",   1'b1, 2'b10, 32'h0FFFFFFC);
      bad("sz_11",    1'b0, 2'b11, 32'h10010004);
      bad("sw_high",  1'b1, 2'b10, 32'h10012000);
      bad("sh_mis",   1'b1, 2'b01, 32'h10010005);
      load("lw_4_chk", 2'b10, 1'b0, 32'h10010004, 32'hDE80BEEF);
      load("lw_0_chk", 2'b10, 1'b0, 32'h10010000, 32'hC1345555);
      idle();

      store("sw_8", 2'b10, 32'h10010008, 32'h11223344);
      idle();
      req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h10010008; wdata = 32'h00000055;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rmw_rst_busy", {31'd0, busy}, 32'd0);
      check("rmw_rst_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      last_load = 32'd0;
      @(negedge clk);
      check("post_rst_rdata", rdata, 32'd0);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      load("lw_8", 2'b10, 1'b0, 32'h10010008, 32'h11223344);
      idle();

      load("b2b_0", 2'b10, 1'b0, 32'h10010000, 32'hC1345555);
      load("b2b_4", 2'b10, 1'b0, 32'h10010004, 32'hDE80BEEF);
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("queue_empty", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory stage directly downstream of the CPU core's load/store port; owns the data RAM array.
- Services word, halfword and byte loads/stores, little-endian. Sign- or zero-extends load results.
- Builds sub-word stores as read-modify-write over a synchronous-read array.
- Drives a combinational stall (`busy`) that the core folds into its PC enable, in the same way the MDU stalls the PC.

Parameters:
- ADDR_W, 11, word-address bits of the array (depth = 2**ADDR_W words).
- BASE_ADDR, 32'h10010000, byte address of array word 0.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  access request; held with all request fields stable while busy=1.
- we  input  1  1=store, 0=load.
- size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend.
- addr  input  32  byte address.
- wdata  input  32  store data; byte/half taken from bits [7:0]/[15:0].
- rdata  output  32  extended load result (registered).
- busy  output  1  combinational; 1 = access not complete this cycle, core must hold.
- done  output  1  combinational; 1 = access completes at this clock edge.
- addr_err  output  1  combinational; 1 = current request illegal, dropped.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - state=IDLE; rdata=0.
  - busy, done and addr_err are forced 0 while rst=1.
  - Array contents are not cleared.
  - A reset during RD or RMW aborts the access with no array write.
- Array: 2**ADDR_W x 32. Write is synchronous. Read is synchronous with registered output (1-cycle latency).
- Word index = (addr - BASE_ADDR) >> 2.
- Lanes:
  - Byte lane k = addr[1:0], bits [8k+7:8k].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- addr_err = req & (size==11 | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | addr<BASE_ADDR | addr>=BASE_ADDR+4*2**ADDR_W).
  - On error: busy=0, done=1, no array write, rdata unchanged, state stays IDLE.
- FSM states: IDLE, RD, RMW.
- IDLE, req=0: busy=0, done=0.
- IDLE, legal word store:
  - Array written at this edge.
  - busy=0, done=1, state stays IDLE (1-cycle access).
- IDLE, legal load or legal sub-word store:
  - Array read issued.
  - busy=1, done=0.
  - Next state is RD for a load, RMW for a store.
- RD:
  - rdata <= lane-selected word data, extended to 32 bits per size and sign_ext; size=10 passes through unchanged.
  - busy=0, done=1, next state IDLE.
- RMW:
  - Array word <= read word with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - busy=0, done=1, next state IDLE. rdata unchanged.
- If req drops while in RD or RMW (protocol violation): return to IDLE, no write, rdata unchanged, done=0.
- A request present in the cycle after done is treated as a new access, starting from IDLE.
- Back-to-back loads therefore take 2 cycles each, with no bubble cycle between them.
- Latency summary:
  - Word store: 1 cycle.
  - Load and sub-word store: 2 cycles (busy high for exactly the first cycle).
  - Error: 1 cycle.
- rdata holds the last completed load value until the next load completes.

Test Plan:
- Reset, then store word 32'hDEADBEEF at 32'h10010004, then load word from 32'h10010004.
  - Store: busy=0, done=1 in the same cycle.
  - Load: busy=1 for 1 cycle, then done=1 with rdata=32'hDEADBEEF.
- Store byte 8'h80 at 32'h10010006 over the word above.
  - RMW takes 2 cycles; the word becomes 32'hDE80BEEF.
  - lb from 32'h10010006 -> 32'hFFFFFF80; lbu -> 32'h00000080.
- Store half 16'h1234 at 32'h10010002, then lh and lhu from 32'h10010002.
  - Word 0 upper half = 16'h1234, lower half unchanged.
  - lh and lhu both return 32'h00001234.
- Illegal requests: lw at 32'h10010001, lh at 32'h10010003, sw at 32'h0FFFFFFC, size=11.
  - Each gives addr_err=1, done=1, busy=0 for one cycle.
  - No array change (read back to confirm); rdata unchanged.
- Assert rst=1 while in RMW for a byte store to 32'h10010008 (word preloaded with 32'h11223344).
  - After reset: state IDLE, outputs 0, word still 32'h11223344.
- Issue two loads back-to-back from 32'h10010000 and 32'h10010004, with req held continuously.
  - done pulses on cycles 2 and 4; busy is high on cycles 1 and 3.
